mccpu_ctrl: RTL and testbench
=============================

Name: mccpu_ctrl

Overview:
Multicycle control FSM for the MIPS CPU. It sequences one shared datapath (single ALU, unified memory port) through fetch/decode/execute/memory/writeback. It replaces the single-cycle combinational controller when the core moves to a multicycle build with a waitable memory. The datapath supplies the IR opcode/funct fields and the ALU Zero flag; this block drives every datapath enable and select.

Parameters:
None. All encodings are fixed in mccpu_pkg.

Ports:
clk  in  1  core clock
rstn  in  1  asynchronous active-low reset
Op  in  6  IR[31:26]; stable from DECODE onward
Funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request; held until mem_ready
IorD  out  1  memory address source: 0 = PC, 1 = ALUOut
IRWrite  out  1  latch instruction register
PCWrite  out  1  update PC from NPC
NPCOp  out  2  00 PC+4, 01 branch, 10 jump
RegWrite  out  1  GPR write enable
GPRSel  out  2  00 rd, 01 rt, 10 r31
WDSel  out  2  00 ALU, 01 MEM, 10 PC
MemWrite  out  2  00 none, 01 sw, 10 sb, 11 sh
LAddr  out  3  load format: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu
EXTOp  out  1  sign-extend immediate
ALUSrc  out  1  ALU B from immediate
ALUOp  out  4  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 SLTU, 8 NOR, 9 XOR, 10 SRLV, 11 SLLV, 12 SRAV
instr_done  out  1  one-cycle pulse when an instruction retires
illegal_instr  out  1  one-cycle pulse on an undecodable instruction

Behaviour:
- Clock and reset: one clock, clk. rstn is asynchronous and active-low.
- Reset: state forced to IDLE immediately. Every output is 0 while in IDLE, and mem_req drops combinationally.
- State register is the only storage. All outputs are Moore-style decodes of state, plus Op/Funct, plus Zero in BRANCH.
- IDLE -> FETCH unconditionally on the first clock after rstn deasserts.
- FETCH: mem_req=1, IorD=0.
  - While mem_ready=0, remain in FETCH with no other strobes.
  - When mem_ready=1: IRWrite=1, PCWrite=1, NPCOp=00, then go to DECODE.
- DECODE: no strobes; dispatch on Op/Funct.
  - Supported R-type funct values -> EXEC_R.
  - addi/ori -> EXEC_I.
  - lw/lb/lh/lbu/lhu/sw/sb/sh -> MEM_ADDR.
  - beq/bne -> BRANCH.
  - j/jal -> JUMP.
  - Anything else: illegal_instr=1, instr_done=1, go to FETCH. The instruction executes as a NOP.
- EXEC_R: ALUOp from funct, ALUSrc=0, then WB_R.
- WB_R: ALUOp held, RegWrite=1, GPRSel=00, WDSel=00, instr_done=1, then FETCH.
- EXEC_I: ALUSrc=1, EXTOp=1 for addi only, ALUOp ADD (addi) or OR (ori), then WB_I.
- WB_I: ALU controls held, RegWrite=1, GPRSel=01, WDSel=00, instr_done=1, then FETCH.
- MEM_ADDR: ALUOp=ADD, ALUSrc=1, EXTOp=1. Loads go to MEM_RD; stores go to MEM_WR.
- MEM_RD: mem_req=1, IorD=1, LAddr per opcode. Remain while mem_ready=0; on mem_ready go to WB_MEM.
- WB_MEM: RegWrite=1, GPRSel=01, WDSel=01, LAddr held, instr_done=1, then FETCH.
- MEM_WR: mem_req=1, IorD=1. MemWrite is driven only in the cycle mem_ready=1; in that cycle instr_done=1 and the next state is FETCH.
- BRANCH: ALUOp=SUB, ALUSrc=0, NPCOp=01. PCWrite = (beq & Zero) | (bne & ~Zero). instr_done=1, then FETCH.
- JUMP: PCWrite=1, NPCOp=10, instr_done=1. For jal additionally RegWrite=1, GPRSel=10, WDSel=10. Then FETCH.
- Zero-wait latencies, counted in cycles from FETCH: R/I-type 4, load 5, store 4, branch 3, jump 3.
- Each wait state adds exactly one cycle per mem_ready=0 cycle.
- mem_req never deasserts before mem_ready while rstn is high.
- Reset mid-operation:
  - A pending memory request is abandoned.
  - A write that has not yet seen mem_ready never asserts MemWrite.
- At most one of RegWrite/MemWrite/PCWrite-to-branch fires per state. instr_done fires exactly once per instruction.

Decomposition:
- mccpu_pkg holds:
  - state enum
  - opcode and funct constants
  - ALUOp, NPCOp, GPRSel, WDSel, MemWrite and LAddr encodings
- Sub-module mccpu_decode is purely combinational. It maps Op/Funct to an instruction-class and ALUOp/LAddr/MemWrite/EXTOp bundle. The FSM in mccpu_ctrl consumes that bundle.

Test Plan:
- Reset: rstn=0 mid-MEM_RD with mem_req=1 -> mem_req=0 the same cycle, all outputs 0. After release: IDLE for 1 cycle, then FETCH.
- add (Op=0, Funct=0x20), mem_ready always 1 -> IRWrite cycle 1, ALUOp=1 in cycles 3-4, RegWrite=1 GPRSel=00 in cycle 4, instr_done once.
- lh (Op=0x21), mem_ready low for 2 cycles in MEM_RD -> 7 total cycles, LAddr=011, WB_MEM asserts RegWrite=1 WDSel=01 GPRSel=01.
- sb (Op=0x28), mem_ready delayed 3 cycles -> MemWrite=10 only in the ready cycle, never earlier, RegWrite never 1.
- beq with Zero=1 -> PCWrite=1 NPCOp=01. bne with Zero=1 -> PCWrite=0. Both retire in 3 cycles.
- jal (Op=0x03) -> PCWrite=1 NPCOp=10 RegWrite=1 GPRSel=10 WDSel=10 in one cycle. Op=0x3F -> illegal_instr pulse, no write strobes, back to FETCH.

Source files
------------

// File: rtl/mccpu_pkg.sv
// mccpu_pkg: shared encodings for the multicycle MIPS control path.
// Holds the FSM state codes, IR opcode/funct values, instruction classes
// and the datapath select encodings driven by mccpu_ctrl.
package mccpu_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_FETCH    = 4'd1;
    localparam state_t S_DECODE   = 4'd2;
    localparam state_t S_EXEC_R   = 4'd3;
    localparam state_t S_WB_R     = 4'd4;
    localparam state_t S_EXEC_I   = 4'd5;
    localparam state_t S_WB_I     = 4'd6;
    localparam state_t S_MEM_ADDR = 4'd7;
    localparam state_t S_MEM_RD   = 4'd8;
    localparam state_t S_WB_MEM   = 4'd9;
    localparam state_t S_MEM_WR   = 4'd10;
    localparam state_t S_BRANCH   = 4'd11;
    localparam state_t S_JUMP     = 4'd12;

    localparam logic [3:0] CLS_ILLEGAL = 4'd0;
    localparam logic [3:0] CLS_R       = 4'd1;
    localparam logic [3:0] CLS_I       = 4'd2;
    localparam logic [3:0] CLS_LOAD    = 4'd3;
    localparam logic [3:0] CLS_STORE   = 4'd4;
    localparam logic [3:0] CLS_BEQ     = 4'd5;
    localparam logic [3:0] CLS_BNE     = 4'd6;
    localparam logic [3:0] CLS_J       = 4'd7;
    localparam logic [3:0] CLS_JAL     = 4'd8;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_SRLV = 4'd10;
    localparam logic [3:0] ALU_SLLV = 4'd11;
    localparam logic [3:0] ALU_SRAV = 4'd12;

    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

    localparam logic [1:0] GPR_RD  = 2'b00;
    localparam logic [1:0] GPR_RT  = 2'b01;
    localparam logic [1:0] GPR_R31 = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_SW   = 2'b01;
    localparam logic [1:0] MW_SB   = 2'b10;
    localparam logic [1:0] MW_SH   = 2'b11;

    localparam logic [2:0] LA_LW  = 3'b000;
    localparam logic [2:0] LA_LB  = 3'b001;
    localparam logic [2:0] LA_LBU = 3'b010;
    localparam logic [2:0] LA_LH  = 3'b011;
    localparam logic [2:0] LA_LHU = 3'b100;

endpackage

// File: rtl/mccpu_decode.sv
// mccpu_decode: combinational opcode/funct classifier.
// Ports: i_op, i_funct (IR fields) in; o_cls (instruction class),
// o_alu_op, o_laddr, o_mem_write, o_ext_op out.
module mccpu_decode
    import mccpu_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output logic [3:0] o_cls,
    output logic [3:0] o_alu_op,
    output logic [2:0] o_laddr,
    output logic [1:0] o_mem_write,
    output logic       o_ext_op
);

    always_comb begin
        o_cls       = CLS_ILLEGAL;
        o_alu_op    = ALU_NOP;
        o_laddr     = LA_LW;
        o_mem_write = MW_NONE;
        o_ext_op    = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                o_cls = CLS_R;
                case (i_funct)
                    F_ADD, F_ADDU: o_alu_op = ALU_ADD;
                    F_SUB, F_SUBU: o_alu_op = ALU_SUB;
                    F_AND:         o_alu_op = ALU_AND;
                    F_OR:          o_alu_op = ALU_OR;
                    F_XOR:         o_alu_op = ALU_XOR;
                    F_NOR:         o_alu_op = ALU_NOR;
                    F_SLT:         o_alu_op = ALU_SLT;
                    F_SLTU:        o_alu_op = ALU_SLTU;
                    F_SLLV:        o_alu_op = ALU_SLLV;
                    F_SRLV:        o_alu_op = ALU_SRLV;
                    F_SRAV:        o_alu_op = ALU_SRAV;
                    default:       o_cls    = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI: begin o_cls = CLS_I; o_alu_op = ALU_ADD; o_ext_op = 1'b1; end
            OP_ORI:  begin o_cls = CLS_I; o_alu_op = ALU_OR; end
            OP_LW:   begin o_cls = CLS_LOAD; o_laddr = LA_LW;  end
            OP_LB:   begin o_cls = CLS_LOAD; o_laddr = LA_LB;  end
            OP_LBU:  begin o_cls = CLS_LOAD; o_laddr = LA_LBU; end
            OP_LH:   begin o_cls = CLS_LOAD; o_laddr = LA_LH;  end
            OP_LHU:  begin o_cls = CLS_LOAD; o_laddr = LA_LHU; end
            OP_SW:   begin o_cls = CLS_STORE; o_mem_write = MW_SW; end
            OP_SB:   begin o_cls = CLS_STORE; o_mem_write = MW_SB; end
            OP_SH:   begin o_cls = CLS_STORE; o_mem_write = MW_SH; end
            OP_BEQ:  begin o_cls = CLS_BEQ; o_alu_op = ALU_SUB; end
            OP_BNE:  begin o_cls = CLS_BNE; o_alu_op = ALU_SUB; end
            OP_J:    o_cls = CLS_J;
            OP_JAL:  o_cls = CLS_JAL;
            default: o_cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mccpu_ctrl.sv
// mccpu_ctrl: multicycle control FSM for the shared MIPS datapath.
// Inputs: clk, rstn (async active-low), Op/Funct (IR fields), Zero, mem_ready.
// Outputs: memory handshake (mem_req, IorD, MemWrite, LAddr), IR/PC/GPR
// strobes and selects, ALU controls, instr_done and illegal_instr pulses.
//
// state    | meaning
// IDLE     | out of reset, all outputs low
// FETCH    | read instruction at PC, wait for mem_ready
// DECODE   | dispatch on Op/Funct; illegal instructions retire here
// EXEC_R   | R-type ALU operation
// WB_R     | write ALU result to rd
// EXEC_I   | immediate ALU operation
// WB_I     | write ALU result to rt
// MEM_ADDR | compute effective address
// MEM_RD   | load request, wait for mem_ready
// WB_MEM   | write load data to rt
// MEM_WR   | store request, write strobe on the mem_ready cycle
// BRANCH   | compare and conditionally redirect PC
// JUMP     | jump, jal also links into r31
module mccpu_ctrl
    import mccpu_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] NPCOp,
    output logic       RegWrite,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic [1:0] MemWrite,
    output logic [2:0] LAddr,
    output logic       EXTOp,
    output logic       ALUSrc,
    output logic [3:0] ALUOp,
    output logic       instr_done,
    output logic       illegal_instr
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_cls;
    logic [3:0] w_alu_op;
    logic [2:0] w_laddr;
    logic [1:0] w_mem_write;
    logic       w_ext_op;

    mccpu_decode u_decode (
        .i_op        (Op),
        .i_funct     (Funct),
        .o_cls       (w_cls),
        .o_alu_op    (w_alu_op),
        .o_laddr     (w_laddr),
        .o_mem_write (w_mem_write),
        .o_ext_op    (w_ext_op)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Outputs decode straight from r_state so an async reset clears them
    // (including mem_req) without waiting for a clock.
    always_comb begin
        w_next        = r_state;
        mem_req       = 1'b0;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        NPCOp         = NPC_PC4;
        RegWrite      = 1'b0;
        GPRSel        = GPR_RD;
        WDSel         = WD_ALU;
        MemWrite      = MW_NONE;
        LAddr         = LA_LW;
        EXTOp         = 1'b0;
        ALUSrc        = 1'b0;
        ALUOp         = ALU_NOP;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_cls)
                    CLS_R:              w_next = S_EXEC_R;
                    CLS_I:              w_next = S_EXEC_I;
                    CLS_LOAD, CLS_STORE: w_next = S_MEM_ADDR;
                    CLS_BEQ, CLS_BNE:   w_next = S_BRANCH;
                    CLS_J, CLS_JAL:     w_next = S_JUMP;
                    default: begin
                        illegal_instr = 1'b1;
                        instr_done    = 1'b1;
                        w_next        = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                ALUOp  = w_alu_op;
                w_next = S_WB_R;
            end
            S_WB_R: begin
                ALUOp      = w_alu_op;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_EXEC_I: begin
                ALUSrc = 1'b1;
                EXTOp  = w_ext_op;
                ALUOp  = w_alu_op;
                w_next = S_WB_I;
            end
            S_WB_I: begin
                ALUSrc     = 1'b1;
                EXTOp      = w_ext_op;
                ALUOp      = w_alu_op;
                RegWrite   = 1'b1;
                GPRSel     = GPR_RT;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALUOp  = ALU_ADD;
                ALUSrc = 1'b1;
                EXTOp  = 1'b1;
                w_next = (w_cls == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                LAddr   = w_laddr;
                if (mem_ready) w_next = S_WB_MEM;
            end
            S_WB_MEM: begin
                RegWrite   = 1'b1;
                GPRSel     = GPR_RT;
                WDSel      = WD_MEM;
                LAddr      = w_laddr;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                // The write strobe is gated by mem_ready so an abandoned
                // store never reaches memory.
                if (mem_ready) begin
                    MemWrite   = w_mem_write;
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end
            end
            S_BRANCH: begin
                ALUOp      = ALU_SUB;
                NPCOp      = NPC_BRANCH;
                PCWrite    = (w_cls == CLS_BEQ) ? Zero : ~Zero;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                NPCOp      = NPC_JUMP;
                instr_done = 1'b1;
                if (w_cls == CLS_JAL) begin
                    RegWrite = 1'b1;
                    GPRSel   = GPR_R31;
                    WDSel    = WD_PC;
                end
                w_next = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mccpu_ctrl.sv
module tb_mccpu_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       IorD;
        logic       IRWrite;
        logic       PCWrite;
        logic [1:0] NPCOp;
        logic       RegWrite;
        logic [1:0] GPRSel;
        logic [1:0] WDSel;
        logic [1:0] MemWrite;
        logic [2:0] LAddr;
        logic       EXTOp;
        logic       ALUSrc;
        logic [3:0] ALUOp;
        logic       instr_done;
        logic       illegal_instr;
    } out_t;

    typedef struct packed {
        logic rdy;
        logic zero;
        out_t want;
    } row_t;

    logic       clk, rstn;
    logic [5:0] Op, Funct;
    logic       Zero, mem_ready;
    logic       mem_req, IorD, IRWrite, PCWrite, RegWrite, EXTOp, ALUSrc;
    logic       instr_done, illegal_instr;
    logic [1:0] NPCOp, GPRSel, WDSel, MemWrite;
    logic [2:0] LAddr;
    logic [3:0] ALUOp;

    out_t outs;
    out_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    assign outs = {mem_req, IorD, IRWrite, PCWrite, NPCOp, RegWrite, GPRSel, WDSel,
                   MemWrite, LAddr, EXTOp, ALUSrc, ALUOp, instr_done, illegal_instr};

    mccpu_ctrl dut (
        .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .NPCOp(NPCOp), .RegWrite(RegWrite), .GPRSel(GPRSel),
        .WDSel(WDSel), .MemWrite(MemWrite), .LAddr(LAddr), .EXTOp(EXTOp),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .instr_done(instr_done),
        .illegal_instr(illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t e_fetch(input logic rdy);
        out_t e = '0;
        e.mem_req = 1'b1;
        if (rdy) begin
            e.IRWrite = 1'b1;
            e.PCWrite = 1'b1;
        end
        return e;
    endfunction

    function automatic row_t mkrow(input logic rdy, input logic z, input out_t e);
        row_t r;
        r.rdy  = rdy;
        r.zero = z;
        r.want = e;
        return r;
    endfunction

    task automatic test_reset();
        out_t got, want;
        @(negedge clk); #1;
        sb_q.push_back('0);
        got = outs; want = sb_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL reset_held got %h want %h", got, want);
        end
        rstn = 1'b1;
        sb_q.push_back('0);
        #1;
        got = outs; want = sb_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL reset_idle got %h want %h", got, want);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        sb_q.push_back(e_fetch(1'b0));
        #1;
        got = outs; want = sb_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL reset_fetch got %h want %h", got, want);
        end
        @(negedge clk);
    endtask

    task automatic test_rtype();
        logic [5:0] fn [6] = '{6'h20, 6'h22, 6'h24, 6'h27, 6'h07, 6'h2B};
        logic [3:0] ao [6] = '{4'd1, 4'd2, 4'd3, 4'd8, 4'd12, 4'd6};
        for (int k = 0; k < 6; k++) begin
            row_t rows[$];
            out_t e, got, want;
            Op = 6'h00; Funct = fn[k];
            rows.push_back(mkrow(1'b1, 1'b0, e_fetch(1'b1)));
            rows.push_back(mkrow(1'b1, 1'b0, '0));
            e = '0; e.ALUOp = ao[k];
            rows.push_back(mkrow(1'b1, 1'b0, e));
            e.RegWrite = 1'b1; e.instr_done = 1'b1;
            rows.push_back(mkrow(1'b1, 1'b0, e));
            foreach (rows[i]) begin
                mem_ready = rows[i].rdy; Zero = rows[i].zero;
                sb_q.push_back(rows[i].want);
                #1;
                got = outs; want = sb_q.pop_front(); vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL rtype f%h cyc%0d got %h want %h", fn[k], i, got, want);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_itype();
        logic [5:0] op [2] = '{6'h08, 6'h0D};
        for (int k = 0; k < 2; k++) begin
            row_t rows[$];
            out_t e, got, want;
            Op = op[k]; Funct = 6'h3F;
            rows.push_back(mkrow(1'b1, 1'b0, e_fetch(1'b1)));
            rows.push_back(mkrow(1'b1, 1'b0, '0));
            e = '0; e.ALUSrc = 1'b1;
            e.EXTOp = (k == 0);
            e.ALUOp = (k == 0) ? 4'd1 : 4'd4;
            rows.push_back(mkrow(1'b1, 1'b0, e));
            e.RegWrite = 1'b1; e.GPRSel = 2'b01; e.instr_done = 1'b1;
            rows.push_back(mkrow(1'b1, 1'b0, e));
            foreach (rows[i]) begin
                mem_ready = rows[i].rdy; Zero = rows[i].zero;
                sb_q.push_back(rows[i].want);
                #1;
                got = outs; want = sb_q.pop_front(); vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL itype op%h cyc%0d got %h want %h", op[k], i, got, want);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_load_wait();
        row_t rows[$];
        out_t e, got, want;
        Op = 6'h21; Funct = 6'h00;
        rows.push_back(mkrow(1'b0, 1'b0, e_fetch(1'b0)));
        rows.push_back(mkrow(1'b1, 1'b0, e_fetch(1'b1)));
        rows.push_back(mkrow(1'b0, 1'b0, '0));
        e = '0; e.ALUOp = 4'd1; e.ALUSrc = 1'b1; e.EXTOp = 1'b1;
        rows.push_back(mkrow(1'b0, 1'b0, e));
        e = '0; e.mem_req = 1'b1; e.IorD = 1'b1; e.LAddr = 3'b011;
        rows.push_back(mkrow(1'b0, 1'b0, e));
        rows.push_back(mkrow(1'b0, 1'b0, e));
        rows.push_back(mkrow(1'b1, 1'b0, e));
        e = '0; e.RegWrite = 1'b1; e.GPRSel = 2'b01; e.WDSel = 2'b01;
        e.LAddr = 3'b011; e.instr_done = 1'b1;
        rows.push_back(mkrow(1'b0, 1'b0, e));
        foreach (rows[i]) begin
            mem_ready = rows[i].rdy; Zero = rows[i].zero;
            sb_q.push_back(rows[i].want);
            #1;
            got = outs; want = sb_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL lh_wait cyc%0d got %h want %h", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_store_wait();
        row_t rows[$];
        out_t e, got, want;
        Op = 6'h28; Funct = 6'h00;
        rows.push_back(mkrow(1'b1, 1'b0, e_fetch(1'b1)));
        rows.push_back(mkrow(1'b1, 1'b0, '0));
        e = '0; e.ALUOp = 4'd1; e.ALUSrc = 1'b1; e.EXTOp = 1'b1;
        rows.push_back(mkrow(1'b1, 1'b0, e));
        e = '0; e.mem_req = 1'b1; e.IorD = 1'b1;
        rows.push_back(mkrow(1'b0, 1'b0, e));
        rows.push_back(mkrow(1'b0, 1'b0, e));
        rows.push_back(mkrow(1'b0, 1'b0, e));
        e.MemWrite = 2'b10; e.instr_done = 1'b1;
        rows.push_back(mkrow(1'b1, 1'b0, e));
        foreach (rows[i]) begin
            mem_ready = rows[i].rdy; Zero = rows[i].zero;
            sb_q.push_back(rows[i].want);
            #1;
            got = outs; want = sb_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL sb_wait cyc%0d got %h want %h", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [5:0] op [3] = '{6'h04, 6'h05, 6'h05};
        logic       zv [3] = '{1'b1, 1'b1, 1'b0};
        logic       pw [3] = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            row_t rows[$];
            out_t e, got, want;
            Op = op[k]; Funct = 6'h00;
            rows.push_back(mkrow(1'b1, zv[k], e_fetch(1'b1)));
            rows.push_back(mkrow(1'b1, zv[k], '0));
            e = '0; e.ALUOp = 4'd2; e.NPCOp = 2'b01; e.PCWrite = pw[k];
            e.instr_done = 1'b1;
            rows.push_back(mkrow(1'b1, zv[k], e));
            foreach (rows[i]) begin
                mem_ready = rows[i].rdy; Zero = rows[i].zero;
                sb_q.push_back(rows[i].want);
                #1;
                got = outs; want = sb_q.pop_front(); vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL branch op%h z%0d cyc%0d got %h want %h", op[k], zv[k], i, got, want);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_jump_illegal();
        logic [5:0] op [3] = '{6'h03, 6'h02, 6'h3F};
        for (int k = 0; k < 3; k++) begin
            row_t rows[$];
            out_t e, got, want;
            Op = op[k]; Funct = 6'h00;
            rows.push_back(mkrow(1'b1, 1'b0, e_fetch(1'b1)));
            e = '0;
            if (k == 2) begin
                e.illegal_instr = 1'b1; e.instr_done = 1'b1;
                rows.push_back(mkrow(1'b1, 1'b0, e));
            end else begin
                rows.push_back(mkrow(1'b1, 1'b0, e));
                e.PCWrite = 1'b1; e.NPCOp = 2'b10; e.instr_done = 1'b1;
                if (k == 0) begin
                    e.RegWrite = 1'b1; e.GPRSel = 2'b10; e.WDSel = 2'b10;
                end
                rows.push_back(mkrow(1'b1, 1'b0, e));
            end
            rows.push_back(mkrow(1'b0, 1'b0, e_fetch(1'b0)));
            foreach (rows[i]) begin
                mem_ready = rows[i].rdy; Zero = rows[i].zero;
                sb_q.push_back(rows[i].want);
                #1;
                got = outs; want = sb_q.pop_front(); vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL jump_ill op%h cyc%0d got %h want %h", op[k], i, got, want);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        row_t rows[$];
        out_t e, got, want;
        Op = 6'h23; Funct = 6'h00;
        rows.push_back(mkrow(1'b1, 1'b0, e_fetch(1'b1)));
        rows.push_back(mkrow(1'b0, 1'b0, '0));
        e = '0; e.ALUOp = 4'd1; e.ALUSrc = 1'b1; e.EXTOp = 1'b1;
        rows.push_back(mkrow(1'b0, 1'b0, e));
        e = '0; e.mem_req = 1'b1; e.IorD = 1'b1;
        rows.push_back(mkrow(1'b0, 1'b0, e));
        foreach (rows[i]) begin
            mem_ready = rows[i].rdy; Zero = rows[i].zero;
            sb_q.push_back(rows[i].want);
            #1;
            got = outs; want = sb_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL rst_mid cyc%0d got %h want %h", i, got, want);
            end
            if (i < rows.size() - 1) @(negedge clk);
        end
        rstn = 1'b0;
        sb_q.push_back('0);
        #1;
        got = outs; want = sb_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL rst_mid_drop got %h want %h", got, want);
        end
        @(negedge clk);
        rstn = 1'b1;
        sb_q.push_back('0);
        #1;
        got = outs; want = sb_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL rst_mid_idle got %h want %h", got, want);
        end
        @(negedge clk);
        sb_q.push_back(e_fetch(1'b0));
        #1;
        got = outs; want = sb_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL rst_mid_fetch got %h want %h", got, want);
        end
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; Op = 6'h00; Funct = 6'h00; Zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_itype();
        test_load_wait();
        test_store_wait();
        test_branch();
        test_jump_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
